rt_lsu_mem_bridge: RTL and testbench

RT-Core load/store bridge sitting directly upstream of the RT port of the partitioned data RAM controller. It accepts byte, halfword and word load/store requests from the RT-Core pipeline, checks their alignment, and converts them into word-only RAM transactions. Sub-word stores are done as read-modify-write. The bridge returns extended load data or a classified error code, and runs entirely in the 50 MHz RT domain.

---
 rtl/rt_lsu_mem_bridge_if.sv | 39 +++
 rtl/rt_lsu_mem_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_rt_lsu_mem_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rt_lsu_mem_bridge_if.sv
// Request/response and RAM-port bundle for the RT-Core load/store bridge.
// The bridge connects through the slave view. The core/RAM side uses the master view.
interface rt_lsu_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic [1:0]            resp_err_code;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;
    logic                  mem_error;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata, mem_ready, mem_error,
        output req_ready, resp_valid, resp_rdata, resp_err_code,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata, mem_ready, mem_error,
        input  req_ready, resp_valid, resp_rdata, resp_err_code,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rt_lsu_mem_bridge.sv
// RT-Core load/store bridge: turns byte/half/word requests into word-only RAM
// accesses. Sub-word stores are done as read-modify-write, and loads are extended.
module rt_lsu_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic               clk_rt_50mhz,
    input  logic               rst_n,
    rt_lsu_mem_bridge_if.slave bus,
    output logic [15:0]        txn_count,
    output logic [15:0]        err_count
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;

    localparam logic [1:0] SZ_BYTE     = 2'b00;
    localparam logic [1:0] SZ_HALF     = 2'b01;
    localparam logic [1:0] SZ_WORD     = 2'b10;
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_BUS     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        we_q, uns_q;
    logic [1:0]  size_q, lane_q;
    logic [31:0] wdata_q;
    logic [7:0]  tmo_cnt;
    logic        accept, issue, issue_wr, go_resp, tmo_clr, tmo_inc;
    logic [1:0]  code_next;
    logic [31:0] rdata_next, mem_wdata_next;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lo[0];
            SZ_WORD: is_misaligned = |lo;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    // Little-endian lane select followed by zero or sign extension.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] sx;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin sx = b; extract_load = uns ? {24'd0, b} : sx; end
            SZ_HALF: begin sx = h; extract_load = uns ? {16'd0, h} : sx; end
            default: extract_load = word;
        endcase
    endfunction

    // Replace only the addressed byte/half of the word read back from RAM.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        merge_store = word;
        case (size)
            SZ_BYTE: merge_store[{lane, 3'b000} +: 8]    = wdata[7:0];
            SZ_HALF: merge_store[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_store = wdata;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign bus.req_ready = (state == IDLE);

    // Next-state logic plus the strobes that load the registered outputs.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        issue          = 1'b0;
        issue_wr       = 1'b0;
        go_resp        = 1'b0;
        tmo_clr        = 1'b0;
        tmo_inc        = 1'b0;
        code_next      = ERR_OK;
        rdata_next     = '0;
        mem_wdata_next = '0;
        case (state)
            IDLE: if (bus.req_valid) begin
                accept = 1'b1;
                if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                    code_next  = ERR_ALIGN;
                end else if (bus.req_we && bus.req_size == SZ_WORD) begin
                    state_next     = WR_ISSUE;
                    issue          = 1'b1;
                    issue_wr       = 1'b1;
                    mem_wdata_next = bus.req_wdata;
                end else begin
                    // loads and the read phase of a sub-word store
                    state_next = RD_ISSUE;
                    issue      = 1'b1;
                end
            end
            RD_ISSUE: begin state_next = RD_WAIT; tmo_clr = 1'b1; end
            WR_ISSUE: begin state_next = WR_WAIT; tmo_clr = 1'b1; end
            RD_WAIT, WR_WAIT: begin
                if (bus.mem_ready) begin
                    if (bus.mem_error) begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                        code_next  = ERR_BUS;
                    end else if (state == RD_WAIT && we_q) begin
                        state_next     = WR_ISSUE;
                        issue          = 1'b1;
                        issue_wr       = 1'b1;
                        mem_wdata_next = merge_store(bus.mem_rdata, wdata_q, size_q, lane_q);
                    end else begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                        if (state == RD_WAIT)
                            rdata_next = extract_load(bus.mem_rdata, size_q, lane_q, uns_q);
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                    code_next  = ERR_TIMEOUT;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Request fields captured on accept; pure data, no reset needed.
    always_ff @(posedge clk_rt_50mhz) begin
        if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            lane_q  <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    // RAM strobes: mem_en is a one-cycle pulse in each ISSUE state.
    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_en <= issue;
            bus.mem_we <= issue_wr;
            if (issue && state == IDLE) bus.mem_addr <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (issue_wr) bus.mem_wdata <= mem_wdata_next;
        end
    end

    // Response registers, loaded on the transition into RESP.
    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid    <= 1'b0;
            bus.resp_rdata    <= '0;
            bus.resp_err_code <= ERR_OK;
        end else begin
            bus.resp_valid <= go_resp;
            if (go_resp) begin
                bus.resp_rdata    <= rdata_next;
                bus.resp_err_code <= code_next;
            end
        end
    end

    // WAIT-cycle counter for the completion timeout.
    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n)       tmo_cnt <= '0;
        else if (tmo_clr) tmo_cnt <= '0;
        else if (tmo_inc) tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Transaction counter wraps, error counter saturates.
    always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
            err_count <= '0;
        end else begin
            if (accept) txn_count <= txn_count + 16'd1;
            if (state == RESP && bus.resp_err_code != ERR_OK) err_count <= sat_inc16(err_count);
        end
    end
endmodule

// File: tb/tb_rt_lsu_mem_bridge.sv
// Bench for rt_lsu_mem_bridge: directed vector table, timeout and reset sequences,
// then random requests checked against a word-array reference model.
module tb_rt_lsu_mem_bridge;
    localparam int TMO = 15;

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_code;
        int          exp_lat;
        int          exp_nmem;
    } vec_t;

    logic        clk_rt_50mhz;
    logic        rst_n;
    logic [15:0] txn_count, err_count;

    rt_lsu_mem_bridge_if #(.ADDR_WIDTH(32)) bus ();

    rt_lsu_mem_bridge #(.TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(32)) dut (
        .clk_rt_50mhz (clk_rt_50mhz),
        .rst_n        (rst_n),
        .bus          (bus),
        .txn_count    (txn_count),
        .err_count    (err_count)
    );

    int          n_cmp, n_fail, cyc, resp_total;
    int          men_cyc[$];
    bit          men_we[$];
    bit [31:0]   ram[int];
    bit [31:0]   gold[int];
    bit          ram_stall;
    int          inject_cyc;
    int          txn_exp, err_exp;
    vec_t        tv[16];

    initial begin
        clk_rt_50mhz = 1'b0;
        forever #10 clk_rt_50mhz = ~clk_rt_50mhz;
    end

    always @(posedge clk_rt_50mhz) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        int key = int'(a >> 2);
        return ram.exists(key) ? ram[key] : 32'd0;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        int key = int'(a >> 2);
        return gold.exists(key) ? gold[key] : 32'd0;
    endfunction

    // RAM: answers 2 cycles after mem_en; region 0x0003xxxx is out of bounds.
    initial begin
        bit s1_v, s2_v, s1_we, s2_we;
        logic [31:0] s1_a, s2_a, s1_d, s2_d;
        s1_v = 0; s2_v = 0; s1_we = 0; s2_we = 0;
        s1_a = 0; s2_a = 0; s1_d = 0; s2_d = 0;
        bus.mem_ready = 1'b0; bus.mem_error = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk_rt_50mhz);
            bus.mem_ready = 1'b0;
            bus.mem_error = 1'b0;
            bus.mem_rdata = $urandom;
            if (s2_v && !ram_stall) begin
                bus.mem_ready = 1'b1;
                if (s2_a[31:16] == 16'h0003) begin
                    bus.mem_error = 1'b1;
                    bus.mem_rdata = 32'hDEADBEEF;
                end else if (s2_we) begin
                    ram[int'(s2_a >> 2)] = s2_d;
                end else begin
                    bus.mem_rdata = ram_rd(s2_a);
                end
            end else if (cyc == inject_cyc) begin
                bus.mem_ready = 1'b1;
            end
            s2_v = s1_v; s2_we = s1_we; s2_a = s1_a; s2_d = s1_d;
            s1_v = (bus.mem_en === 1'b1); s1_we = bus.mem_we; s1_a = bus.mem_addr; s1_d = bus.mem_wdata;
        end
    end

    // Log every RAM strobe and response pulse.
    initial begin
        forever begin
            @(negedge clk_rt_50mhz);
            if (bus.mem_en === 1'b1) begin
                men_cyc.push_back(cyc);
                men_we.push_back(bus.mem_we);
            end
            if (bus.resp_valid === 1'b1) resp_total++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected outcome from the bridge rules applied to a word array.
    function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rdata, output logic [1:0] code,
                                  output int lat, output int nmem);
        int unsigned w, sh, v;
        int key = int'(addr >> 2);
        rdata = 0; code = 0; lat = 4; nmem = 1;
        if (size == 3 || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)) begin
            code = 1; lat = 1; nmem = 0;
            return;
        end
        if (addr[31:16] == 16'h0003) begin
            code = 2;
            return;
        end
        w  = gold.exists(key) ? gold[key] : 0;
        sh = (size == 1) ? 16 * ((addr % 4) / 2) : 8 * (addr % 4);
        if (!we) begin
            if (size == 2) v = w;
            else if (size == 0) begin
                v = (w >> sh) % 256;
                if (!uns && v >= 128) v = v - 256;
            end else begin
                v = (w >> sh) % 65536;
                if (!uns && v >= 32768) v = v - 65536;
            end
            rdata = v;
        end else begin
            if (size == 2) w = wd;
            else if (size == 0) begin
                w = w - (((w >> sh) % 256) << sh) + ((wd % 256) << sh);
                lat = 7; nmem = 2;
            end else begin
                w = w - (((w >> sh) % 65536) << sh) + ((wd % 65536) << sh);
                lat = 7; nmem = 2;
            end
            gold[key] = w;
        end
    endfunction

    task automatic send_req(input bit we, input logic [1:0] size, input bit uns,
                            input logic [31:0] addr, input logic [31:0] wd, output int acc);
        @(posedge clk_rt_50mhz); #1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            @(negedge clk_rt_50mhz);
            if (bus.req_ready === 1'b1) acc = cyc;
            @(posedge clk_rt_50mhz); #1;
        end
        bus.req_valid = 1'b0;
        if (acc < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL accept: req_ready never high, required 1 within 50 cycles");
        end
    endtask

    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int inject_off,
                          output logic [31:0] rdata, output logic [1:0] code, output int acc,
                          output int lat, output int nmem, output int first_off, output bit last_we);
        bit got;
        send_req(we, size, uns, addr, wd, acc);
        if (inject_off > 0) inject_cyc = acc + inject_off;
        got = 0; lat = -1; rdata = 'x; code = 'x;
        for (int i = 0; i < 400 && !got && acc >= 0; i++) begin
            @(negedge clk_rt_50mhz);
            if (bus.resp_valid === 1'b1) begin
                got = 1; lat = cyc - acc; rdata = bus.resp_rdata; code = bus.resp_err_code;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL resp: resp_valid not seen, required within 400 cycles");
        end
        nmem = 0; first_off = -1; last_we = 0;
        foreach (men_cyc[k]) begin
            if (men_cyc[k] > acc) begin
                nmem++;
                if (first_off < 0) first_off = men_cyc[k] - acc;
                last_we = men_we[k];
            end
        end
        men_cyc.delete();
        men_we.delete();
    endtask

    initial begin
        logic [31:0] rd, erd, saved;
        logic [1:0]  code, ecode, size;
        int          acc, lat, nmem, fo, elat, enmem, prev_end, rt0, nw;
        bit          lw, we, uns;
        logic [31:0] addr, wd;
        int          r;

        n_cmp = 0; n_fail = 0; cyc = 0; resp_total = 0;
        ram_stall = 0; inject_cyc = -1; txn_exp = 0; err_exp = 0;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0;

        tv[0]  = '{1, 2'b10, 0, 32'h00020010, 32'hCAFEBABE, 32'h00000000, 2'd0, 4, 1};
        tv[1]  = '{0, 2'b10, 0, 32'h00020010, 32'h0,        32'hCAFEBABE, 2'd0, 4, 1};
        tv[2]  = '{1, 2'b10, 0, 32'h00020010, 32'h11223344, 32'h00000000, 2'd0, 4, 1};
        tv[3]  = '{1, 2'b00, 0, 32'h00020011, 32'h000000A5, 32'h00000000, 2'd0, 7, 2};
        tv[4]  = '{0, 2'b10, 0, 32'h00020010, 32'h0,        32'h1122A544, 2'd0, 4, 1};
        tv[5]  = '{0, 2'b00, 0, 32'h00020011, 32'h0,        32'hFFFFFFA5, 2'd0, 4, 1};
        tv[6]  = '{0, 2'b00, 1, 32'h00020011, 32'h0,        32'h000000A5, 2'd0, 4, 1};
        tv[7]  = '{0, 2'b01, 0, 32'h00020013, 32'h0,        32'h00000000, 2'd1, 1, 0};
        tv[8]  = '{0, 2'b11, 0, 32'h00020010, 32'h0,        32'h00000000, 2'd1, 1, 0};
        tv[9]  = '{0, 2'b10, 0, 32'h00030000, 32'h0,        32'h00000000, 2'd2, 4, 1};
        tv[10] = '{1, 2'b00, 0, 32'h00030001, 32'h0000005A, 32'h00000000, 2'd2, 4, 1};
        tv[11] = '{1, 2'b01, 0, 32'h00020012, 32'h1234BEEF, 32'h00000000, 2'd0, 7, 2};
        tv[12] = '{0, 2'b01, 0, 32'h00020012, 32'h0,        32'hFFFFBEEF, 2'd0, 4, 1};
        tv[13] = '{0, 2'b01, 1, 32'h00020010, 32'h0,        32'h0000A544, 2'd0, 4, 1};
        tv[14] = '{0, 2'b00, 0, 32'h00020013, 32'h0,        32'hFFFFFFBE, 2'd0, 4, 1};
        tv[15] = '{1, 2'b10, 0, 32'h00020012, 32'h12345678, 32'h00000000, 2'd1, 1, 0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk_rt_50mhz);
        @(negedge clk_rt_50mhz);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_code", bus.resp_err_code, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_err", err_count, 0);
        @(posedge clk_rt_50mhz); #1;
        rst_n = 1'b1;

        // Directed vectors, issued back to back
        prev_end = 0;
        for (int i = 0; i < 16; i++) begin
            model(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, erd, ecode, elat, enmem);
            txn_exp++;
            if (ecode != 0) err_exp++;
            do_req(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, 0,
                   rd, code, acc, lat, nmem, fo, lw);
            chk($sformatf("tv%0d_rdata", i), rd, tv[i].exp_rdata);
            chk($sformatf("tv%0d_code", i), code, tv[i].exp_code);
            chk($sformatf("tv%0d_latency", i), lat, tv[i].exp_lat);
            chk($sformatf("tv%0d_mem_en_count", i), nmem, tv[i].exp_nmem);
            if (tv[i].exp_nmem > 0) chk($sformatf("tv%0d_mem_en_cycle", i), fo, 1);
            if (tv[i].exp_nmem > 0 && tv[i].exp_code == 0)
                chk($sformatf("tv%0d_last_we", i), lw, tv[i].we);
            if (i > 0) chk($sformatf("tv%0d_back_to_back", i), acc, prev_end + 1);
            prev_end = acc + lat;
        end
        @(posedge clk_rt_50mhz); #1;
        chk("tv_ram_word", ram_rd(32'h00020010), 32'hBEEFA544);
        chk("tv_txn_count", txn_count, txn_exp);
        chk("tv_err_count", err_count, err_exp);

        // Timeout: RAM stays silent, then a late mem_ready arrives in cycle 18
        ram_stall = 1;
        do_req(0, 2'b10, 0, 32'h00020000, 32'h0, 18, rd, code, acc, lat, nmem, fo, lw);
        ram_stall = 0;
        txn_exp++; err_exp++;
        chk("to_code", code, 3);
        chk("to_rdata", rd, 0);
        chk("to_latency", lat, 2 + TMO);
        chk("to_mem_en_count", nmem, 1);
        rt0 = resp_total;
        repeat (6) @(posedge clk_rt_50mhz); #1;
        chk("to_late_ready_ignored", resp_total, rt0);
        chk("to_mem_en_after", men_cyc.size(), 0);
        chk("to_req_ready", bus.req_ready, 1);
        chk("to_err_count", err_count, err_exp);
        chk("to_txn_count", txn_count, txn_exp);
        inject_cyc = -1;

        // Random requests against the reference model
        for (int i = 0; i < 150; i++) begin
            r    = $urandom_range(0, 99);
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = (r < 5) ? 2'b11 : 2'($urandom_range(0, 2));
            addr = (r >= 5 && r < 15) ? 32'h00030000 + 32'($urandom_range(0, 15))
                                      : 32'h00020000 + 32'($urandom_range(0, 31));
            wd   = $urandom;
            model(we, size, uns, addr, wd, erd, ecode, elat, enmem);
            txn_exp++;
            if (ecode != 0) err_exp++;
            do_req(we, size, uns, addr, wd, 0, rd, code, acc, lat, nmem, fo, lw);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_code", i), code, ecode);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
            chk($sformatf("rnd%0d_mem_en_count", i), nmem, enmem);
            if (enmem > 0 && ecode == 0) chk($sformatf("rnd%0d_last_we", i), lw, we);
        end
        @(posedge clk_rt_50mhz); #1;
        for (int k = 0; k < 8; k++)
            chk($sformatf("ram_word_%0d", k), ram_rd(32'h00020000 + 32'(4 * k)), gold_rd(32'h00020000 + 32'(4 * k)));
        chk("rnd_txn_count", txn_count, txn_exp);
        chk("rnd_err_count", err_count, err_exp);

        // Reset in the middle of a byte store, before the write phase is issued
        men_cyc.delete(); men_we.delete();
        rt0   = resp_total;
        saved = ram_rd(32'h00020004);
        send_req(1, 2'b00, 0, 32'h00020005, 32'h00000077, acc);
        repeat (2) @(posedge clk_rt_50mhz); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_rt_50mhz); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk_rt_50mhz); #1;
        nw = 0;
        foreach (men_we[k]) if (men_we[k]) nw++;
        chk("rst_mid_no_write", nw, 0);
        chk("rst_mid_no_resp", resp_total, rt0);
        chk("rst_mid_req_ready", bus.req_ready, 1);
        chk("rst_mid_txn", txn_count, 0);
        chk("rst_mid_err", err_count, 0);
        chk("rst_mid_ram_word", ram_rd(32'h00020004), saved);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
